// File: rtl/seq_addsub16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : seq_addsub16 (with add_sub_4 slice)                             |
// | Multi-cycle signed add/subtract, one 4-bit CLA nibble per clock, with    |
// | optional saturation and V/Z/N/Cout flags behind a valid/ready handshake. |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+

module add_sub_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Flat lookahead: every carry depends only on g/p and the slice carry-in.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_s    = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];
endmodule

module seq_addsub16 #(
    parameter int NIBBLES  = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   Sum,
    output logic                   Cout,
    output logic                   V,
    output logic                   Z,
    output logic                   N
);
    localparam int c_w  = 4 * NIBBLES;
    localparam int c_iw = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_iw-1:0] c_last = c_iw'(NIBBLES - 1);
    localparam logic [c_w-1:0]  c_smax = {1'b0, {(c_w-1){1'b1}}};
    localparam logic [c_w-1:0]  c_smin = {1'b1, {(c_w-1){1'b0}}};

    typedef enum logic [1:0] {
        c_idle = 2'd0,
        c_calc = 2'd1,
        c_done = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_iw-1:0] r_idx;
    logic            r_carry;
    logic [c_w-1:0]  r_a;
    logic [c_w-1:0]  r_b;
    logic [c_w-1:0]  r_raw;
    logic [c_w-1:0]  r_sum;
    logic            r_cout;
    logic            r_v;
    logic            r_z;
    logic            r_n;
    logic            r_out_valid;

    logic [3:0]      w_s;
    logic            w_co;
    logic [c_w-1:0]  w_raw_next;
    logic [c_w-1:0]  w_sum_final;
    logic            w_ovf;

    add_sub_4 u_slice (
        .i_a    (r_a[{r_idx, 2'b00} +: 4]),
        .i_b    (r_b[{r_idx, 2'b00} +: 4]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_co)
    );

    // On the last CALC edge the top nibble is still in flight, so the final
    // result is formed from the partial sum with the current nibble merged in.
    always_comb begin
        w_raw_next = r_raw;
        w_raw_next[{r_idx, 2'b00} +: 4] = w_s;
        w_ovf = (r_a[c_w-1] == r_b[c_w-1]) && (w_raw_next[c_w-1] != r_a[c_w-1]);
        w_sum_final = w_raw_next;
        if (SATURATE && w_ovf) begin
            w_sum_final = r_a[c_w-1] ? c_smin : c_smax;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_raw       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_v         <= 1'b0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= sub ? ~B : B;
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_state <= c_calc;
                    end
                end
                c_calc: begin
                    r_raw   <= w_raw_next;
                    r_carry <= w_co;
                    if (r_idx == c_last) begin
                        r_sum       <= w_sum_final;
                        r_cout      <= w_co;
                        r_v         <= w_ovf;
                        r_z         <= (w_sum_final == '0);
                        r_n         <= w_sum_final[c_w-1];
                        r_out_valid <= 1'b1;
                        r_state     <= c_done;
                    end else begin
                        r_idx <= r_idx + c_iw'(1);
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = r_out_valid;
    assign Sum       = r_sum;
    assign Cout      = r_cout;
    assign V         = r_v;
    assign Z         = r_z;
    assign N         = r_n;
endmodule

`default_nettype wire

// File: tb/tb_seq_addsub16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_seq_addsub16                                                 |
// | Bench for seq_addsub16: saturating and wrapping instances, checked       |
// | against an integer-arithmetic reference model.                           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_seq_addsub16;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        sub;
    logic        out_ready;
    logic [15:0] A;
    logic [15:0] B;

    logic        in_ready_s, out_valid_s, cout_s, v_s, z_s, n_s;
    logic [15:0] sum_s;
    logic        in_ready_w, out_valid_w, cout_w, v_w, z_w, n_w;
    logic [15:0] sum_w;

    int tests;
    int fails;

    seq_addsub16 #(.NIBBLES(4), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .A(A), .B(B), .sub(sub), .out_valid(out_valid_s), .out_ready(out_ready),
        .Sum(sum_s), .Cout(cout_s), .V(v_s), .Z(z_s), .N(n_s)
    );

    seq_addsub16 #(.NIBBLES(4), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .A(A), .B(B), .sub(sub), .out_valid(out_valid_w), .out_ready(out_ready),
        .Sum(sum_w), .Cout(cout_w), .V(v_w), .Z(z_w), .N(n_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed result decides overflow; result packed as {Sum,Cout,V,Z,N}.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input bit sat);
        logic [16:0] full;
        int          exact;
        logic        ovf;
        logic [15:0] res;
        if (s) begin
            full  = {1'b0, a} + {1'b0, ~b} + 17'd1;
            exact = int'($signed(a)) - int'($signed(b));
        end else begin
            full  = {1'b0, a} + {1'b0, b};
            exact = int'($signed(a)) + int'($signed(b));
        end
        ovf = (exact > 32767) || (exact < -32768);
        res = full[15:0];
        if (sat && ovf) res = (exact > 0) ? 16'h7FFF : 16'h8000;
        return {res, full[16], ovf, (res == 16'h0000), res[15]};
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output int lat, output bit tmo);
        A = a; B = b; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        tmo = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid_s) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; sub = 1'b0;
        #12;
        tests++;
        if ({in_ready_s, out_valid_s, sum_s, cout_s, v_s, z_s, n_s} !== {1'b1, 1'b0, 20'h0} ||
            {in_ready_w, out_valid_w, sum_w, cout_w, v_w, z_w, n_w} !== {1'b1, 1'b0, 20'h0}) begin
            fails++;
            $display("FAIL reset: sat rdy=%b vld=%b out=%h wrap rdy=%b vld=%b out=%h, want rdy=1 vld=0 out=0",
                     in_ready_s, out_valid_s, {sum_s, cout_s, v_s, z_s, n_s},
                     in_ready_w, out_valid_w, {sum_w, cout_w, v_w, z_w, n_w});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [15:0] ta [6] = '{16'h1234, 16'h7FFF, 16'h8000, 16'h0005, 16'hFFFF, 16'h0000};
        logic [15:0] tb [6] = '{16'h0101, 16'h0001, 16'h0001, 16'h0005, 16'h0001, 16'h8000};
        logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] tsum [6] = '{16'h1335, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h7FFF};
        logic [19:0] exp_s, exp_w;
        int lat;
        bit tmo;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], ts[i], lat, tmo);
            exp_s = model(ta[i], tb[i], ts[i], 1'b1);
            exp_w = model(ta[i], tb[i], ts[i], 1'b0);
            tests++;
            if (tmo || lat != 4) begin
                fails++;
                $display("FAIL directed[%0d] latency: got %0d (timeout=%0d), want 4", i, lat, tmo);
            end
            tests++;
            if (sum_s !== tsum[i]) begin
                fails++;
                $display("FAIL directed[%0d] sum const: got %h, want %h", i, sum_s, tsum[i]);
            end
            tests++;
            if ({sum_s, cout_s, v_s, z_s, n_s} !== exp_s) begin
                fails++;
                $display("FAIL directed[%0d] sat {sum,c,v,z,n}: got %h, want %h", i,
                         {sum_s, cout_s, v_s, z_s, n_s}, exp_s);
            end
            tests++;
            if ({sum_w, cout_w, v_w, z_w, n_w} !== exp_w) begin
                fails++;
                $display("FAIL directed[%0d] wrap {sum,c,v,z,n}: got %h, want %h", i,
                         {sum_w, cout_w, v_w, z_w, n_w}, exp_w);
            end
            release_out();
        end
    endtask

    task automatic test_hold();
        logic [19:0] exp_s;
        bit seen;
        exp_s = model(16'h4000, 16'h4000, 1'b0, 1'b1);
        A = 16'h4000; B = 16'h4000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        // Stray request during CALC and DONE must be ignored.
        A = 16'h0001; B = 16'h0002; sub = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(posedge clk); #1;
            seen = out_valid_s;
        end
        tests++;
        if (!seen || {sum_s, cout_s, v_s, z_s, n_s} !== exp_s) begin
            fails++;
            $display("FAIL hold first result: valid=%b got %h, want %h", seen,
                     {sum_s, cout_s, v_s, z_s, n_s}, exp_s);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({out_valid_s, in_ready_s, sum_s, cout_s, v_s, z_s, n_s} !== {1'b1, 1'b0, exp_s}) begin
                fails++;
                $display("FAIL hold cycle %0d: vld=%b rdy=%b out=%h, want vld=1 rdy=0 out=%h", i,
                         out_valid_s, in_ready_s, {sum_s, cout_s, v_s, z_s, n_s}, exp_s);
            end
        end
        in_valid = 1'b0;
        release_out();
        tests++;
        if ({out_valid_s, in_ready_s, sum_s, cout_s, v_s, z_s, n_s} !== {1'b0, 1'b1, exp_s}) begin
            fails++;
            $display("FAIL hold release: vld=%b rdy=%b out=%h, want vld=0 rdy=1 out=%h",
                     out_valid_s, in_ready_s, {sum_s, cout_s, v_s, z_s, n_s}, exp_s);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_s;
        int lat;
        bit tmo;
        run_op(16'h0F0F, 16'h00F1, 1'b0, lat, tmo);
        A = 16'h9000; B = 16'h2000; sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if ({out_valid_s, in_ready_s} !== 2'b01) begin
            fails++;
            $display("FAIL b2b handshake edge: vld=%b rdy=%b, want vld=0 rdy=1", out_valid_s, in_ready_s);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (in_ready_s !== 1'b0) begin
            fails++;
            $display("FAIL b2b accept: rdy=%b, want 0", in_ready_s);
        end
        lat = 0; tmo = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid_s) begin tmo = 1'b0; break; end
        end
        exp_s = model(16'h9000, 16'h2000, 1'b1, 1'b1);
        tests++;
        if (tmo || lat != 4 || {sum_s, cout_s, v_s, z_s, n_s} !== exp_s) begin
            fails++;
            $display("FAIL b2b second: lat=%0d tmo=%0d got %h, want lat=4 %h", lat, tmo,
                     {sum_s, cout_s, v_s, z_s, n_s}, exp_s);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        logic [19:0] exp_s;
        int lat;
        bit tmo;
        bit early;
        run_op(16'h1111, 16'h2222, 1'b0, lat, tmo);
        release_out();
        A = 16'h7000; B = 16'h7000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({out_valid_s, in_ready_s, sum_s, cout_s, v_s, z_s, n_s} !== {1'b0, 1'b1, 20'h0} ||
            {out_valid_w, in_ready_w, sum_w, cout_w, v_w, z_w, n_w} !== {1'b0, 1'b1, 20'h0}) begin
            fails++;
            $display("FAIL reset mid-calc: sat vld=%b rdy=%b out=%h wrap out=%h, want vld=0 rdy=1 out=0",
                     out_valid_s, in_ready_s, {sum_s, cout_s, v_s, z_s, n_s},
                     {sum_w, cout_w, v_w, z_w, n_w});
        end
        #2 rst = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid_s || out_valid_w) early = 1'b1;
        end
        tests++;
        if (early) begin
            fails++;
            $display("FAIL reset abort: out_valid=1 seen after reset, want 0");
        end
        run_op(16'hABCD, 16'h1234, 1'b1, lat, tmo);
        exp_s = model(16'hABCD, 16'h1234, 1'b1, 1'b1);
        tests++;
        if (tmo || lat != 4 || {sum_s, cout_s, v_s, z_s, n_s} !== exp_s) begin
            fails++;
            $display("FAIL post-reset op: lat=%0d tmo=%0d got %h, want lat=4 %h", lat, tmo,
                     {sum_s, cout_s, v_s, z_s, n_s}, exp_s);
        end
        release_out();
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic        s;
        logic [19:0] exp_s, exp_w;
        int lat;
        bit tmo;
        for (int i = 0; i < 48; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom);
            if (i % 8 == 3) b = 16'h8000;
            if (i % 8 == 5) a = 16'h8000;
            run_op(a, b, s, lat, tmo);
            exp_s = model(a, b, s, 1'b1);
            exp_w = model(a, b, s, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            tests++;
            if (tmo || lat != 4) begin
                fails++;
                $display("FAIL random[%0d] latency: got %0d (timeout=%0d), want 4", i, lat, tmo);
            end
            tests++;
            if ({sum_s, cout_s, v_s, z_s, n_s} !== exp_s ||
                {sum_w, cout_w, v_w, z_w, n_w} !== exp_w) begin
                fails++;
                $display("FAIL random[%0d] a=%h b=%h sub=%b: sat %h wrap %h, want sat %h wrap %h",
                         i, a, b, s, {sum_s, cout_s, v_s, z_s, n_s},
                         {sum_w, cout_w, v_w, z_w, n_w}, exp_s, exp_w);
            end
            release_out();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
